// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit adder among NREQ requesters and
// returns each sum through a single registered response slot tagged with its requester.
`timescale 1ns/1ps
module adder_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*WIDTH-1:0] req_a_i,
    input  logic [NREQ*WIDTH-1:0] req_b_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [WIDTH-1:0]      rsp_sum_o,
    output logic                  rsp_carry_o,
    output logic [IDW-1:0]        rsp_id_o,
    output logic [15:0]           grant_count_o
);

    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]      grant_count_q, grant_count_d;

    logic [2*NREQ-1:0] rot_s;
    logic              found_s;
    logic [IDW:0]      offset_s;
    logic [IDW:0]      gsum_s;
    logic [IDW-1:0]    grant_s;
    logic              can_accept_s;
    logic              accept_s;
    logic [WIDTH-1:0]  a_sel_s;
    logic [WIDTH-1:0]  b_sel_s;
    logic [WIDTH:0]    add_s;

    // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        rot_s    = {req_valid_i, req_valid_i} >> rr_ptr_q;
        found_s  = 1'b0;
        offset_s = {(IDW+1){1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && rot_s[k]) begin
                found_s  = 1'b1;
                offset_s = (IDW+1)'(k);
            end else begin
                offset_s = offset_s;
            end
        end
        gsum_s = {1'b0, rr_ptr_q} + offset_s;
        if (gsum_s >= (IDW+1)'(NREQ)) begin
            grant_s = IDW'(gsum_s - (IDW+1)'(NREQ));
        end else begin
            grant_s = gsum_s[IDW-1:0];
        end
        can_accept_s = !rsp_valid_q || rsp_ready_i;
        accept_s     = !rst && can_accept_s && found_s;
        if (accept_s) begin
            req_ready_o = {{(NREQ-1){1'b0}}, 1'b1} << grant_s;
        end else begin
            req_ready_o = {NREQ{1'b0}};
        end
    end

    // Shared adder on the granted operands, and next state of the response slot.
    always_comb begin
        a_sel_s       = req_a_i[grant_s*WIDTH +: WIDTH];
        b_sel_s       = req_b_i[grant_s*WIDTH +: WIDTH];
        add_s         = {1'b0, a_sel_s} + {1'b0, b_sel_s};
        rsp_valid_d   = rsp_valid_q;
        rsp_sum_d     = rsp_sum_q;
        rsp_carry_d   = rsp_carry_q;
        rsp_id_d      = rsp_id_q;
        rr_ptr_d      = rr_ptr_q;
        grant_count_d = grant_count_q;
        if (accept_s) begin
            rsp_valid_d   = 1'b1;
            rsp_sum_d     = add_s[WIDTH-1:0];
            rsp_carry_d   = add_s[WIDTH];
            rsp_id_d      = grant_s;
            rr_ptr_d      = (grant_s == IDW'(NREQ-1)) ? {IDW{1'b0}} : grant_s + IDW'(1);
            grant_count_d = grant_count_q + 16'd1;
        end else if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q   <= 1'b0;
            rsp_sum_q     <= {WIDTH{1'b0}};
            rsp_carry_q   <= 1'b0;
            rsp_id_q      <= {IDW{1'b0}};
            rr_ptr_q      <= {IDW{1'b0}};
            grant_count_q <= 16'd0;
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_sum_q     <= rsp_sum_d;
            rsp_carry_q   <= rsp_carry_d;
            rsp_id_q      <= rsp_id_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_count_q <= grant_count_d;
        end
    end

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_sum_o     = rsp_sum_q;
    assign rsp_carry_o   = rsp_carry_q;
    assign rsp_id_o      = rsp_id_q;
    assign grant_count_o = grant_count_q;

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one WIDTH-bit adder datapath between NREQ requesters using round-robin arbitration and a valid/ready handshake.
- Accepted operands are summed and returned through a single registered response slot, tagged with the requester index.
- Sits between stimulus/accumulator clients and the shared adder so that no requester needs its own adder instance.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- WIDTH, 16, operand and sum width in bits.
- IDW, $clog2(NREQ), requester index width; minimum 1.

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  NREQ  bit i set = requester i presents operands.
- req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot or zero; bit i = requester i accepted this cycle.
- rsp_valid  output  1  response slot holds a result.
- rsp_ready  input  1  consumer takes the response this cycle.
- rsp_sum  output  WIDTH  (a+b) mod 2^WIDTH.
- rsp_carry  output  1  carry-out of a+b.
- rsp_id  output  IDW  index of the requester that produced the response.
- grant_count  output  16  running count of accepted requests; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset: rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, grant_count=0, rr_ptr=0. req_ready=0 while rst is high.
- can_accept = !rsp_valid || rsp_ready. The response slot frees and refills in the same cycle.
- Arbitration (combinational):
  - If can_accept is set and any req_valid bit is set, grant the first valid requester found by scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[g]=1 only for that requester g; all other bits are 0.
  - If can_accept is 0, req_ready is all-zero.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i].
  - Requesters hold req_valid and operands stable until accepted.
  - req_ready may depend combinationally on req_valid; requesters must not make req_valid depend on req_ready.
- On accept of requester g (posedge):
  - rsp_sum <= low WIDTH bits of (a_g+b_g), rsp_carry <= bit WIDTH of the (WIDTH+1)-bit sum.
  - rsp_id <= g, rsp_valid <= 1.
  - rr_ptr <= (g+1) mod NREQ, grant_count <= grant_count+1.
- Latency: one cycle from accept to rsp_valid=1. Throughput: one result per cycle while rsp_ready=1.
- Response retire: rsp_valid && rsp_ready with no new accept gives rsp_valid <= 0; rsp_sum, rsp_carry and rsp_id hold their last values.
- Backpressure: while rsp_valid=1 and rsp_ready=0, all response outputs hold stable and no request is accepted. rr_ptr and grant_count hold.
- No valid requesters: rr_ptr unchanged.
- Reset mid-operation: a pending response is discarded (rsp_valid=0 on the cycle after rst). Requests presented during rst are not accepted and are not counted.
- Arithmetic: operands are unsigned; there is no saturation.

Test Plan:
- Single request: after reset, req_valid=4'b0001, a=16'h1234, b=16'h0001, rsp_ready=1 -> req_ready=4'b0001 in the same cycle; next cycle rsp_valid=1, rsp_sum=16'h1235, rsp_carry=0, rsp_id=0, grant_count=1.
- Round-robin fairness: all four requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1; exactly one req_ready bit per cycle; grant_count=6 after 6 accepts.
- Backpressure: accept requester 2, then hold rsp_ready=0 for 5 cycles with requesters 0 and 3 valid -> req_ready=0 throughout and rsp_sum/rsp_id stable. When rsp_ready=1, the same cycle grants requester 3 (rr_ptr=3) and the next response has rsp_id=3.
- Carry/wrap: a=16'hFFFF, b=16'h0001 -> rsp_sum=16'h0000, rsp_carry=1. A second case a=16'h8000, b=16'h8000 -> rsp_sum=0, rsp_carry=1.
- Reset mid-operation: rsp_valid=1, rsp_ready=0, then assert rst for 1 cycle -> next cycle rsp_valid=0, grant_count=0. First post-reset grant goes to the lowest valid index scanning from 0.
- Counter wrap: force 65536 accepts with one requester and rsp_ready=1 -> grant_count returns to 0; responses are unaffected.
